dvb_cmd_unpack: RTL and testbench
=================================

# dvb_cmd_unpack

Frame buffer and byte serializer placed directly downstream of the PCIe DMA write path. It accepts 64-bit DVB command frames marked by `dvb_cmd_sof`/`dvb_cmd_eof`, checks each frame against its embedded length field, and commits only complete, well-formed frames. Committed frames are replayed as a byte stream with a valid/ready handshake to the DVB modulator command port. Malformed or overflowing frames are dropped whole.

## Interface
- `DEPTH_LOG2`, 9: log2 of frame RAM depth in 64-bit words (512).
- `DESC_LOG2`, 3: log2 of descriptor FIFO depth (8 frames).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `dvb_cmd_dout` in 64: frame word; byte 0 = bits [7:0], sent first.
- `dvb_cmd_dout_en` in 1: word valid; no backpressure exists.
- `dvb_cmd_sof` in 1: first word of a frame; qualified by `dvb_cmd_dout_en`.
- `dvb_cmd_eof` in 1: last word of a frame; qualified by `dvb_cmd_dout_en`; may coincide with sof.
- `cmd_byte` out 8: output byte.
- `cmd_byte_en` out 1: output valid.
- `cmd_byte_sof` / `cmd_byte_eof` out 1: first and last byte of a frame.
- `cmd_byte_rdy` in 1: sink ready; a byte transfers when en and rdy are both high.
- `cmd_frame_cnt` out 16: committed frames (see Configuration).
- `cmd_drop_cnt` out 16: dropped frames (see Configuration).

## Operation
- Length: on the sof word, the payload length is `L = {w[4:0], w[15:8]}` (13 bits). Total bytes `T = L + 2`, computed in 14 bits. Expected words `N = ceil(T/8) = (T + 7) >> 3`.
- Write FSM states:
  - W_IDLE: a sof word goes to W_FRAME and writes the word.
  - W_FRAME: writes each en word at `wptr_spec`, counts words, and on eof goes to W_IDLE.
  - A non-sof word seen in W_IDLE is discarded silently and is not counted.
- Commit on eof happens when all of these hold: word count == N, no overflow flagged, and descriptor FIFO not full. Commit sets `wptr_commit <= wptr_spec + 1` and pushes T.
- Drop rewinds `wptr_spec <= wptr_commit` and increments the drop count. Drop causes:
  - Length mismatch at eof.
  - Word count exceeding N before eof (flagged, dropped at eof).
  - Frame RAM full: `wptr_spec + 1 == rptr`. The write is suppressed and the overflow flag is set.
  - Descriptor FIFO full at eof.
- A sof arriving while in W_FRAME drops the open frame in the same cycle and starts the new frame at `wptr_commit`.
- Pointers are `DEPTH_LOG2` bits and wrap modulo depth. One slot is kept empty to distinguish full from empty.
- Read FSM states:
  - R_IDLE: pop a descriptor when the FIFO is non-empty, then go to R_FETCH.
  - R_FETCH: issue a RAM read at `rptr`.
  - R_BYTE: present bytes 0..7 of the fetched word in order. After byte 7, or after the last byte of the frame, advance `rptr` and go to R_FETCH. After the frame's last byte (T bytes total), go to R_IDLE.
- `cmd_byte_sof` is asserted on byte 0 of the frame; `cmd_byte_eof` on byte T-1. The pad bytes of the final word are never emitted.
- While `cmd_byte_en` is high, `cmd_byte` and its flags hold stable until `cmd_byte_rdy`.

## Timing
- All outputs reset to 0. All pointers reset to 0, FSMs reset to idle, and counters reset to 0. A reset mid-frame discards every frame in flight and every committed frame.
- Frame RAM has 1-cycle read latency.
- Earliest output: if the eof word is accepted at cycle c, descriptor push is at c+1, pop at c+2, RAM read at c+3, and `cmd_byte_en` rises at c+4.
- Throughput is 1 byte/cycle within a word, with one bubble cycle per word fetch.
- A commit and a pop in the same cycle are both honoured; the descriptor count is unchanged.
- Reads never pass `wptr_commit`, so speculative data is never emitted.

## Configuration
- `DVB_CMD_STATS_EN`:
  - Defined: `cmd_frame_cnt` increments on each commit and `cmd_drop_cnt` on each drop. Both saturate at 16'hFFFF.
  - Undefined: no counter logic is built and both outputs are tied to 0.

## Structure
- Package `dvb_cmd_pkg`: `DVB_CMD_HDR_BYTES = 2`, the length-field extraction function, the word-count function, and the enums for the write and read FSM states.
- Sub-module `dvb_cmd_frame_ram`: simple dual-port RAM, 2^DEPTH_LOG2 × 64, registered read.
- The descriptor FIFO is inline logic (a small register array).

## Test plan
- Single frame, L=14 (T=16, N=2), two words with sof/eof, rdy held high -> 16 bytes emitted in lane order, sof on byte 0, eof on byte 15, `cmd_frame_cnt`=1.
- L=7 (T=9, N=2): the last word carries 1 valid byte -> exactly 9 bytes out, pad bytes absent.
- L=14 but eof on word 3 -> no bytes out, `cmd_drop_cnt`=1. A following good frame is emitted intact.
- Second sof mid-frame -> first frame dropped, second frame emitted intact, drop count 1.
- Toggle `cmd_byte_rdy` at random with rdy=0 for 10 cycles mid-word -> byte and flags stay stable, no byte lost or duplicated.
- Hold rdy=0 and send 9 frames of T=16 -> 8 committed and the 9th dropped (descriptor FIFO full). Releasing rdy yields 8 intact frames.

Source files
------------

// File: rtl/dvb_cmd_pkg.sv
// Shared FSM encodings and frame-header helpers for the DVB command unpacker.
package dvb_cmd_pkg;

    localparam int DVB_CMD_HDR_BYTES = 2;

    typedef enum logic [0:0] {W_IDLE, W_FRAME} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_BYTE} r_state_t;

    // Payload length sits in the first two bytes: byte 0 bits [4:0] are the MSBs.
    function automatic logic [12:0] dvb_len(input logic [15:0] hdr);
        return {hdr[4:0], hdr[15:8]};
    endfunction

    function automatic logic [13:0] dvb_total(input logic [12:0] len);
        return {1'b0, len} + 14'(DVB_CMD_HDR_BYTES);
    endfunction

    function automatic logic [11:0] dvb_words(input logic [13:0] total);
        logic [13:0] sum;
        sum = total + 14'd7;
        return {1'b0, sum[13:3]};
    endfunction

endpackage

// File: rtl/dvb_cmd_frame_ram.sv
// Simple dual-port frame RAM with a registered read port.
module dvb_cmd_frame_ram #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dvb_cmd_unpack.sv
// Buffers 64-bit DVB command frames, commits only well-formed ones and replays them as bytes.
// Optional frame/drop statistics counters are built when DVB_CMD_STATS_EN is defined.
module dvb_cmd_unpack
    import dvb_cmd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int DESC_LOG2  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dvb_cmd_dout,
    input  logic        dvb_cmd_dout_en,
    input  logic        dvb_cmd_sof,
    input  logic        dvb_cmd_eof,
    output logic [7:0]  cmd_byte,
    output logic        cmd_byte_en,
    output logic        cmd_byte_sof,
    output logic        cmd_byte_eof,
    input  logic        cmd_byte_rdy,
    output logic [15:0] cmd_frame_cnt,
    output logic [15:0] cmd_drop_cnt
);

    localparam int DESC_DEPTH = 2**DESC_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;

    logic [DEPTH_LOG2-1:0] wptr_spec, wptr_commit, rptr, wr_addr;
    logic [11:0] wcnt, n_exp, cnt_nx, n_nx;
    logic [13:0] t_exp, t_nx, push_t, t_rem;
    logic        ovf, ovf_nx, ram_full, wr_en, in_word, commit, drop_eof, push_pend;

    logic [13:0]          desc_mem [DESC_DEPTH];
    logic [DESC_LOG2-1:0] dwp, drp;
    logic [DESC_LOG2:0]   dcnt;
    logic                 desc_full, desc_empty, desc_rel;

    logic        rd_en, xfer, last_byte, word_done, first;
    logic [2:0]  bcnt;
    logic [63:0] rd_data;

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = w_state;
        if (in_word) w_state_nx = dvb_cmd_eof ? W_IDLE : W_FRAME;
    end

    always_comb begin
        in_word  = dvb_cmd_dout_en && (dvb_cmd_sof || w_state == W_FRAME);
        wr_addr  = dvb_cmd_sof ? wptr_commit : wptr_spec;
        ram_full = (wr_addr + PTR_ONE) == rptr;
        wr_en    = in_word && !ram_full;
        cnt_nx   = dvb_cmd_sof ? 12'd1 : wcnt + 12'd1;
        t_nx     = dvb_cmd_sof ? dvb_total(dvb_len(dvb_cmd_dout[15:0])) : t_exp;
        n_nx     = dvb_cmd_sof ? dvb_words(t_nx) : n_exp;
        ovf_nx   = (!dvb_cmd_sof && ovf) || ram_full || (cnt_nx > n_nx);
        // A push still in flight occupies a slot already.
        desc_full = ({1'b0, dcnt} + (DESC_LOG2+2)'(push_pend)) >= (DESC_LOG2+2)'(DESC_DEPTH);
        commit   = in_word && dvb_cmd_eof && !ovf_nx && (cnt_nx == n_nx) && !desc_full;
        drop_eof = in_word && dvb_cmd_eof && !commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_spec   <= '0;
            wptr_commit <= '0;
            wcnt        <= '0;
            n_exp       <= '0;
            t_exp       <= '0;
            ovf         <= 1'b0;
            push_pend   <= 1'b0;
            push_t      <= '0;
        end else begin
            push_pend <= commit;
            if (in_word) begin
                wcnt  <= ovf_nx ? wcnt : cnt_nx;
                n_exp <= n_nx;
                t_exp <= t_nx;
                ovf   <= ovf_nx;
                if (commit) begin
                    wptr_spec   <= wr_addr + PTR_ONE;
                    wptr_commit <= wr_addr + PTR_ONE;
                    push_t      <= t_nx;
                end else if (drop_eof) begin
                    wptr_spec <= wptr_commit;
                end else if (wr_en) begin
                    wptr_spec <= wr_addr + PTR_ONE;
                end else begin
                    wptr_spec <= wr_addr;
                end
            end
        end
    end

    // A descriptor is held until its frame is fully emitted, so in-flight frames count toward depth.
    always_ff @(posedge clk) begin
        if (push_pend) desc_mem[dwp] <= push_t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwp  <= '0;
            drp  <= '0;
            dcnt <= '0;
        end else begin
            if (push_pend) dwp <= dwp + DESC_LOG2'(1);
            if (desc_rel)  drp <= drp + DESC_LOG2'(1);
            dcnt <= dcnt + (DESC_LOG2+1)'(push_pend) - (DESC_LOG2+1)'(desc_rel);
        end
    end

    assign desc_empty = (dcnt == '0);

    dvb_cmd_frame_ram #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(64)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (dvb_cmd_dout),
        .rd_en   (rd_en),
        .rd_addr (rptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE:  if (!desc_empty) r_state_nx = R_FETCH;
            R_FETCH: r_state_nx = R_BYTE;
            R_BYTE: begin
                if (desc_rel)       r_state_nx = R_IDLE;
                else if (word_done) r_state_nx = R_FETCH;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_comb begin
        rd_en        = (r_state == R_FETCH);
        cmd_byte_en  = (r_state == R_BYTE);
        last_byte    = (t_rem == 14'd1);
        xfer         = cmd_byte_en && cmd_byte_rdy;
        desc_rel     = xfer && last_byte;
        word_done    = xfer && (last_byte || bcnt == 3'd7);
        cmd_byte     = cmd_byte_en ? rd_data[{bcnt, 3'b000} +: 8] : 8'd0;
        cmd_byte_sof = cmd_byte_en && first;
        cmd_byte_eof = cmd_byte_en && last_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            bcnt  <= '0;
            t_rem <= '0;
            first <= 1'b0;
        end else begin
            if (r_state == R_IDLE && !desc_empty) begin
                t_rem <= desc_mem[drp];
                first <= 1'b1;
            end
            if (r_state == R_FETCH) bcnt <= 3'd0;
            if (xfer) begin
                t_rem <= t_rem - 14'd1;
                first <= 1'b0;
                bcnt  <= bcnt + 3'd1;
            end
            if (word_done) rptr <= rptr + PTR_ONE;
        end
    end

`ifdef DVB_CMD_STATS_EN
    logic        drop_sof;
    logic [16:0] frame_sum, drop_sum;

    always_comb begin
        drop_sof  = dvb_cmd_dout_en && dvb_cmd_sof && (w_state == W_FRAME);
        frame_sum = {1'b0, cmd_frame_cnt} + 17'(commit);
        drop_sum  = {1'b0, cmd_drop_cnt} + 17'(drop_eof) + 17'(drop_sof);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_frame_cnt <= '0;
            cmd_drop_cnt  <= '0;
        end else begin
            cmd_frame_cnt <= frame_sum[16] ? 16'hFFFF : frame_sum[15:0];
            cmd_drop_cnt  <= drop_sum[16]  ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    assign cmd_frame_cnt = '0;
    assign cmd_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_dvb_cmd_unpack.sv
// Self-checking bench for dvb_cmd_unpack: frame vector table plus hand-written corner sequences.
module tb_dvb_cmd_unpack;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_byte_t;

    typedef struct {
        logic [12:0] len;
        int          nwords;
        bit          ok;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] dvb_cmd_dout;
    logic        dvb_cmd_dout_en;
    logic        dvb_cmd_sof;
    logic        dvb_cmd_eof;
    logic [7:0]  cmd_byte;
    logic        cmd_byte_en;
    logic        cmd_byte_sof;
    logic        cmd_byte_eof;
    logic        cmd_byte_rdy;
    logic [15:0] cmd_frame_cnt;
    logic [15:0] cmd_drop_cnt;

    always #5 clk = ~clk;

    dvb_cmd_unpack dut (
        .clk             (clk),
        .rst             (rst),
        .dvb_cmd_dout    (dvb_cmd_dout),
        .dvb_cmd_dout_en (dvb_cmd_dout_en),
        .dvb_cmd_sof     (dvb_cmd_sof),
        .dvb_cmd_eof     (dvb_cmd_eof),
        .cmd_byte        (cmd_byte),
        .cmd_byte_en     (cmd_byte_en),
        .cmd_byte_sof    (cmd_byte_sof),
        .cmd_byte_eof    (cmd_byte_eof),
        .cmd_byte_rdy    (cmd_byte_rdy),
        .cmd_frame_cnt   (cmd_frame_cnt),
        .cmd_drop_cnt    (cmd_drop_cnt)
    );

    exp_byte_t   sb[$];
    exp_byte_t   mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_frames = 0;
    int          exp_drops = 0;
    logic [63:0] fw [16];
    logic        hold_q = 1'b0;
    logic [7:0]  hold_byte;
    logic        hold_sof, hold_eof;

    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                n_cmp++;
                if (!(cmd_byte_en && cmd_byte == hold_byte && cmd_byte_sof == hold_sof && cmd_byte_eof == hold_eof)) begin
                    n_err++;
                    $display("FAIL hold_stable: got en=%0b byte=%02h sof=%0b eof=%0b, want en=1 byte=%02h sof=%0b eof=%0b",
                             cmd_byte_en, cmd_byte, cmd_byte_sof, cmd_byte_eof, hold_byte, hold_sof, hold_eof);
                end
            end
            if (cmd_byte_en && cmd_byte_rdy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got byte=%02h sof=%0b eof=%0b, want no byte", cmd_byte, cmd_byte_sof, cmd_byte_eof);
                end else begin
                    mon_e = sb.pop_front();
                    if (cmd_byte !== mon_e.data || cmd_byte_sof !== mon_e.sof || cmd_byte_eof !== mon_e.eof) begin
                        n_err++;
                        $display("FAIL byte_out: got byte=%02h sof=%0b eof=%0b, want byte=%02h sof=%0b eof=%0b",
                                 cmd_byte, cmd_byte_sof, cmd_byte_eof, mon_e.data, mon_e.sof, mon_e.eof);
                    end
                end
            end
            hold_q    = cmd_byte_en && !cmd_byte_rdy;
            hold_byte = cmd_byte;
            hold_sof  = cmd_byte_sof;
            hold_eof  = cmd_byte_eof;
        end
    end

    function automatic logic [15:0] exp_cnt(input int n);
        logic [15:0] v;
        v = (n > 65535) ? 16'hFFFF : 16'(n);
`ifndef DVB_CMD_STATS_EN
        v = 16'd0;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [63:0] w, input logic s, input logic e);
        dvb_cmd_dout    = w;
        dvb_cmd_dout_en = 1'b1;
        dvb_cmd_sof     = s;
        dvb_cmd_eof     = e;
        tick();
        dvb_cmd_dout_en = 1'b0;
        dvb_cmd_sof     = 1'b0;
        dvb_cmd_eof     = 1'b0;
    endtask

    task automatic build_frame(input logic [12:0] len);
        for (int i = 0; i < 16; i++) fw[i] = {$urandom, $urandom};
        fw[0][15:8] = len[7:0];
        fw[0][4:0]  = len[12:8];
    endtask

    task automatic push_exp(input logic [12:0] len);
        int t;
        logic [63:0] w;
        t = int'(len) + 2;
        for (int b = 0; b < t; b++) begin
            w = fw[b / 8];
            sb.push_back('{data: w[(b % 8) * 8 +: 8], sof: (b == 0), eof: (b == t - 1)});
        end
        exp_frames++;
    endtask

    task automatic send_frame(input int nw);
        for (int i = 0; i < nw; i++) drive_word(fw[i], (i == 0), (i == nw - 1));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || cmd_byte_en) && k < budget) begin
            tick();
            k++;
        end
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s drain: got %0d bytes still pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_counts(input string name);
        n_cmp++;
        if (cmd_frame_cnt !== exp_cnt(exp_frames) || cmd_drop_cnt !== exp_cnt(exp_drops)) begin
            n_err++;
            $display("FAIL %s counts: got frames=%0d drops=%0d, want frames=%0d drops=%0d",
                     name, cmd_frame_cnt, cmd_drop_cnt, exp_cnt(exp_frames), exp_cnt(exp_drops));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [9];
        int   first_k;
        int   k;

        vt[0] = '{len: 13'd14,  nwords: 2,  ok: 1'b1};
        vt[1] = '{len: 13'd7,   nwords: 2,  ok: 1'b1};
        vt[2] = '{len: 13'd14,  nwords: 3,  ok: 1'b0};
        vt[3] = '{len: 13'd6,   nwords: 1,  ok: 1'b1};
        vt[4] = '{len: 13'd0,   nwords: 1,  ok: 1'b1};
        vt[5] = '{len: 13'd30,  nwords: 4,  ok: 1'b1};
        vt[6] = '{len: 13'd7,   nwords: 1,  ok: 1'b0};
        vt[7] = '{len: 13'd100, nwords: 13, ok: 1'b1};
        vt[8] = '{len: 13'd21,  nwords: 3,  ok: 1'b1};

        rst             = 1'b1;
        dvb_cmd_dout    = '0;
        dvb_cmd_dout_en = 1'b0;
        dvb_cmd_sof     = 1'b0;
        dvb_cmd_eof     = 1'b0;
        cmd_byte_rdy    = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({cmd_byte_en, cmd_byte_sof, cmd_byte_eof, cmd_byte, cmd_frame_cnt, cmd_drop_cnt} !== 43'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%0b sof=%0b eof=%0b byte=%02h frames=%0d drops=%0d, want all 0",
                     cmd_byte_en, cmd_byte_sof, cmd_byte_eof, cmd_byte, cmd_frame_cnt, cmd_drop_cnt);
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            build_frame(vt[i].len);
            if (vt[i].ok) push_exp(vt[i].len);
            else          exp_drops++;
            send_frame(vt[i].nwords);
            wait_drain($sformatf("vec%0d", i), 400);
            check_counts($sformatf("vec%0d", i));
        end

        // Earliest output: en must rise four cycles after the eof cycle.
        build_frame(13'd6);
        push_exp(13'd6);
        dvb_cmd_dout    = fw[0];
        dvb_cmd_dout_en = 1'b1;
        dvb_cmd_sof     = 1'b1;
        dvb_cmd_eof     = 1'b1;
        first_k = 0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j == 1) begin
                dvb_cmd_dout_en = 1'b0;
                dvb_cmd_sof     = 1'b0;
                dvb_cmd_eof     = 1'b0;
            end
            if (cmd_byte_en && first_k == 0) first_k = j;
        end
        n_cmp++;
        if (first_k != 4) begin
            n_err++;
            $display("FAIL latency: got en rising at cycle %0d, want 4", first_k);
        end
        wait_drain("latency", 100);
        check_counts("latency");

        drive_word({$urandom, $urandom}, 1'b0, 1'b1);
        repeat (6) tick();
        check_counts("stray_word");

        build_frame(13'd14);
        drive_word(fw[0], 1'b1, 1'b0);
        drive_word(fw[1], 1'b0, 1'b0);
        exp_drops++;
        build_frame(13'd14);
        push_exp(13'd14);
        send_frame(2);
        wait_drain("mid_sof", 200);
        check_counts("mid_sof");

        cmd_byte_rdy = 1'b0;
        build_frame(13'd100);
        push_exp(13'd100);
        send_frame(13);
        k = 0;
        while (!cmd_byte_en && k < 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!cmd_byte_en) begin
            n_err++;
            $display("FAIL rdy_wait: got en=0 after %0d cycles, want en=1", k);
        end
        cmd_byte_rdy = 1'b1;
        repeat (3) tick();
        cmd_byte_rdy = 1'b0;
        repeat (10) tick();
        k = 0;
        while ((sb.size() != 0 || cmd_byte_en) && k < 1000) begin
            cmd_byte_rdy = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        cmd_byte_rdy = 1'b1;
        wait_drain("rdy_toggle", 100);
        check_counts("rdy_toggle");

        cmd_byte_rdy = 1'b0;
        for (int f = 0; f < 9; f++) begin
            build_frame(13'd14);
            if (f < 8) push_exp(13'd14);
            else       exp_drops++;
            send_frame(2);
        end
        repeat (5) tick();
        check_counts("fifo_full_held");
        cmd_byte_rdy = 1'b1;
        wait_drain("fifo_full", 600);
        check_counts("fifo_full");

        cmd_byte_rdy = 1'b0;
        build_frame(13'd14);
        send_frame(2);
        build_frame(13'd14);
        drive_word(fw[0], 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_frames = 0;
        exp_drops  = 0;
        n_cmp++;
        if (cmd_byte_en !== 1'b0 || cmd_byte !== 8'd0 || cmd_byte_sof !== 1'b0 || cmd_byte_eof !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got en=%0b byte=%02h sof=%0b eof=%0b, want all 0",
                     cmd_byte_en, cmd_byte, cmd_byte_sof, cmd_byte_eof);
        end
        check_counts("mid_reset");
        cmd_byte_rdy = 1'b1;
        repeat (30) tick();
        build_frame(13'd7);
        push_exp(13'd7);
        send_frame(2);
        wait_drain("post_reset", 200);
        check_counts("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
